mult_control_unit: RTL and testbench

//   Sequencer and adder for the shift-add unsigned multiplier; sits directly upstream of product_register.

---
 rtl/mult_control_unit_if.sv | 54 +++++
 rtl/mult_control_unit.sv | 108 ++++++++++
 tb/tb_mult_control_unit.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_control_unit_if.sv
// Handshake and product-register bundle for the shift-add multiplier
// sequencer. The slave side is the sequencer itself.
interface mult_control_unit_if #(
  parameter int WIDTH = 64
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_multiplicand;
  logic [WIDTH-1:0]   in_multiplier;
  logic [2*WIDTH:0]   prod_in;
  logic [WIDTH:0]     prod_data;
  logic [WIDTH-1:0]   prod_initial_data;
  logic               prod_initial_wr;
  logic               prod_wr;
  logic               prod_sh_right;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;
  logic               busy;

  modport slave (
    input  in_valid,
    input  in_multiplicand,
    input  in_multiplier,
    input  prod_in,
    input  out_ready,
    output in_ready,
    output prod_data,
    output prod_initial_data,
    output prod_initial_wr,
    output prod_wr,
    output prod_sh_right,
    output out_valid,
    output out_product,
    output busy
  );

  modport master (
    output in_valid,
    output in_multiplicand,
    output in_multiplier,
    output prod_in,
    output out_ready,
    input  in_ready,
    input  prod_data,
    input  prod_initial_data,
    input  prod_initial_wr,
    input  prod_wr,
    input  prod_sh_right,
    input  out_valid,
    input  out_product,
    input  busy
  );
endinterface

// File: rtl/mult_control_unit.sv
// Sequencer and adder for the shift-add unsigned multiplier: accepts an
// operand pair, steps product_register WIDTH times, presents the product.
module mult_control_unit #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  mult_control_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;

  logic in_ready;
  logic out_valid;
  logic busy;
  logic init_wr;
  logic add_wr;
  logic sh_right;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      mcand_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mcand_q <= mcand_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mcand_d   = mcand_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    init_wr   = 1'b0;
    add_wr    = 1'b0;
    sh_right  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          mcand_d = bus.in_multiplicand;
          count_d = '0;
          init_wr = 1'b1;
          state_d = ITER;
        end
      end
      ITER: begin
        busy = 1'b1;
        // LSB of the product register is the current multiplier bit
        if (bus.prod_in[0]) begin
          add_wr = 1'b1;
        end else begin
          sh_right = 1'b1;
        end
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // An aborted operation must not touch the product register
    if (reset) begin
      init_wr   = 1'b0;
      add_wr    = 1'b0;
      sh_right  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
    end
  end

  assign bus.in_ready          = in_ready;
  assign bus.out_valid         = out_valid;
  assign bus.busy              = busy;
  assign bus.prod_initial_wr   = init_wr;
  assign bus.prod_wr           = add_wr;
  assign bus.prod_sh_right     = sh_right;
  assign bus.prod_initial_data = bus.in_multiplier;
  assign bus.out_product       = bus.prod_in[2*WIDTH-1:0];

  // Carry lands in bit WIDTH; the register shifts it back in
  assign bus.prod_data = {1'b0, bus.prod_in[2*WIDTH-1:WIDTH]}
                       + {1'b0, mcand_q};
endmodule

// File: tb/tb_mult_control_unit.sv
// Directed bench for mult_control_unit with a behavioural
// product_register attached to its strobes.
module tb_mult_control_unit;
  localparam int W = 64;

  logic clk;
  logic reset;

  mult_control_unit_if #(.WIDTH(W)) bus ();

  mult_control_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  logic [2*W:0] prod_q;
  int passed = 0;
  int total  = 0;
  int n_wr    = 0;
  int n_sh    = 0;
  int n_multi = 0;
  int n_stray = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.prod_in = prod_q;

  // product_register: load, add-and-shift, shift-only
  always @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
    end else if (bus.prod_initial_wr) begin
      prod_q <= {{(W+1){1'b0}}, bus.prod_initial_data};
    end else if (bus.prod_wr) begin
      prod_q <= {1'b0, bus.prod_data, prod_q[W-1:1]};
    end else if (bus.prod_sh_right) begin
      prod_q <= prod_q >> 1;
    end
  end

  always @(negedge clk) begin
    if (bus.prod_wr) n_wr <= n_wr + 1;
    if (bus.prod_sh_right) n_sh <= n_sh + 1;
    if (({1'b0, bus.prod_initial_wr} + {1'b0, bus.prod_wr}
         + {1'b0, bus.prod_sh_right}) > 2'd1)
      n_multi <= n_multi + 1;
    if ((bus.prod_initial_wr && !(bus.in_ready && bus.in_valid))
        || ((bus.prod_wr || bus.prod_sh_right)
            && !(bus.busy && !bus.out_valid)))
      n_stray <= n_stray + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first ITER cycle after accept
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    bus.in_valid        = 1'b1;
    bus.in_multiplicand = a;
    bus.in_multiplier   = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Latency counted from the accept cycle; returns in the first DONE cycle
  task automatic wait_valid(output int lat);
    int n;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      tick();
      n++;
    end
    lat = n + 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_multiplicand = '0;
    bus.in_multiplier = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    else passed++;
    total++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    else passed++;
    total++;
    if (bus.busy !== 1'b0)
      $display("FAIL reset_busy: got %b want 0", bus.busy);
    else passed++;
    total++;
    if ({bus.prod_initial_wr, bus.prod_wr, bus.prod_sh_right} !== 3'b000)
      $display("FAIL reset_strobes: got %b want 000",
               {bus.prod_initial_wr, bus.prod_wr, bus.prod_sh_right});
    else passed++;
  endtask

  task automatic test_basic();
    int lat, w0, s0;
    bus.out_ready = 1'b1;
    w0 = n_wr;
    s0 = n_sh;
    bus.in_valid = 1'b1;
    bus.in_multiplicand = 64'd3;
    bus.in_multiplier = 64'd5;
    #1;
    total++;
    if (bus.prod_initial_wr !== 1'b1)
      $display("FAIL basic_init_wr: got %b want 1", bus.prod_initial_wr);
    else passed++;
    tick();
    bus.in_valid = 1'b0;
    total++;
    if ({bus.busy, bus.in_ready} !== 2'b10)
      $display("FAIL basic_iter_flags: got %b want 10",
               {bus.busy, bus.in_ready});
    else passed++;
    wait_valid(lat);
    total++;
    if (lat !== W + 1)
      $display("FAIL basic_latency: got %0d want %0d", lat, W + 1);
    else passed++;
    total++;
    if (bus.out_product !== 128'd15)
      $display("FAIL basic_product: got %0h want f", bus.out_product);
    else passed++;
    total++;
    if ((n_wr - w0) !== 2 || (n_sh - s0) !== 62)
      $display("FAIL basic_strobe_counts: got wr=%0d sh=%0d want 2 62",
               n_wr - w0, n_sh - s0);
    else passed++;
    tick();
    total++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100)
      $display("FAIL basic_back_idle: got %b want 100",
               {bus.in_ready, bus.out_valid, bus.busy});
    else passed++;
  endtask

  task automatic test_all_ones();
    int lat;
    bus.out_ready = 1'b1;
    start('1, '1);
    wait_valid(lat);
    total++;
    if (bus.out_product !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001)
      $display("FAIL ones_product: got %0h want fffffffffffffffe0000000000000001",
               bus.out_product);
    else passed++;
    tick();
  endtask

  task automatic test_zero_multiplier();
    int lat, w0, s0;
    bus.out_ready = 1'b1;
    w0 = n_wr;
    s0 = n_sh;
    start(64'h1234, 64'd0);
    wait_valid(lat);
    total++;
    if ((n_wr - w0) !== 0 || (n_sh - s0) !== W)
      $display("FAIL zero_strobes: got wr=%0d sh=%0d want 0 %0d",
               n_wr - w0, n_sh - s0, W);
    else passed++;
    total++;
    if (bus.out_product !== 128'd0)
      $display("FAIL zero_product: got %0h want 0", bus.out_product);
    else passed++;
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    bit stable;
    bus.out_ready = 1'b0;
    start(64'd7, 64'd9);
    wait_valid(lat);
    bus.in_valid = 1'b1;
    bus.in_multiplicand = 64'd5;
    bus.in_multiplier = 64'd11;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!bus.out_valid || bus.out_product !== 128'd63
          || bus.in_ready || bus.prod_initial_wr)
        stable = 1'b0;
      tick();
    end
    total++;
    if (stable !== 1'b1)
      $display("FAIL bp_hold: got %b want 1 (product %0h)",
               stable, bus.out_product);
    else passed++;
    bus.out_ready = 1'b1;
    #1;
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b10)
      $display("FAIL bp_release_cycle: got %b want 10",
               {bus.out_valid, bus.in_ready});
    else passed++;
    tick();
    total++;
    if ({bus.in_ready, bus.prod_initial_wr} !== 2'b11)
      $display("FAIL bp_accept_next: got %b want 11",
               {bus.in_ready, bus.prod_initial_wr});
    else passed++;
    tick();
    bus.in_valid = 1'b0;
    wait_valid(lat);
    total++;
    if (bus.out_product !== 128'd55)
      $display("FAIL bp_next_product: got %0h want 37", bus.out_product);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid_op();
    int lat;
    bit seen;
    bus.out_ready = 1'b1;
    start(64'd11, 64'd13);
    for (int i = 0; i < 20; i++) tick();
    reset = 1'b1;
    #1;
    total++;
    if ({bus.prod_initial_wr, bus.prod_wr, bus.prod_sh_right,
         bus.out_valid} !== 4'b0000)
      $display("FAIL rst_mid_strobes: got %b want 0000",
               {bus.prod_initial_wr, bus.prod_wr, bus.prod_sh_right,
                bus.out_valid});
    else passed++;
    tick();
    reset = 1'b0;
    #1;
    total++;
    if ({bus.in_ready, bus.busy} !== 2'b10)
      $display("FAIL rst_mid_idle: got %b want 10",
               {bus.in_ready, bus.busy});
    else passed++;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    total++;
    if (seen !== 1'b0)
      $display("FAIL rst_mid_no_valid: got %b want 0", seen);
    else passed++;
    start(64'd2, 64'd2);
    wait_valid(lat);
    total++;
    if (bus.out_product !== 128'd4)
      $display("FAIL rst_mid_after: got %0h want 4", bus.out_product);
    else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, lat2, m0;
    bus.out_ready = 1'b1;
    m0 = n_multi;
    bus.in_valid = 1'b1;
    bus.in_multiplicand = 64'd6;
    bus.in_multiplier = 64'd7;
    tick();
    bus.in_multiplicand = 64'h8000_0000_0000_0000;
    bus.in_multiplier = 64'd2;
    wait_valid(lat);
    total++;
    if (bus.out_product !== 128'd42)
      $display("FAIL b2b_first: got %0h want 2a", bus.out_product);
    else passed++;
    tick();
    total++;
    if ({bus.in_ready, bus.prod_initial_wr} !== 2'b11)
      $display("FAIL b2b_accept: got %b want 11",
               {bus.in_ready, bus.prod_initial_wr});
    else passed++;
    total++;
    if (lat + 1 !== W + 2)
      $display("FAIL b2b_period: got %0d want %0d", lat + 1, W + 2);
    else passed++;
    tick();
    bus.in_valid = 1'b0;
    wait_valid(lat2);
    total++;
    if (bus.out_product !== 128'h1_0000_0000_0000_0000)
      $display("FAIL b2b_second: got %0h want 10000000000000000",
               bus.out_product);
    else passed++;
    total++;
    if ((n_multi - m0) !== 0)
      $display("FAIL b2b_onehot: got %0d overlaps want 0", n_multi - m0);
    else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_ones();
    test_zero_multiplier();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    total++;
    if (n_stray !== 0 || n_multi !== 0)
      $display("FAIL strobe_hygiene: got stray=%0d overlap=%0d want 0 0",
               n_stray, n_multi);
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
